// File: rtl/twpm_wb_pkg.sv
// Shared Wishbone copy-engine types: FSM encoding, failure codes, byte-select constant.
package twpm_wb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_code_t;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    // Word-align a byte address; the low two bits are don't-care on input.
    function automatic logic [31:0] word_adr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Per-bus-cycle watchdog: counts cycles while en is high, cleared by clr.
// expired is combinational from the count; it saturates rather than wrapping.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // The strobe is high for count+1 cycles, so expiry at TIMEOUT-1 drops it after TIMEOUT cycles.
    assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_block_copy.sv
// Wishbone classic memory-to-memory word copier: one read then one write per word.
// Bus cycles are separated by one idle cycle; each cycle waits for ack/err up to TIMEOUT_CYCLES.
module wb_block_copy
    import twpm_wb_pkg::*;
#(
    parameter int LEN_WIDTH      = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [31:0]          src_adr_i,
    input  logic [31:0]          dst_adr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o,
    output logic [LEN_WIDTH-1:0] words_done_o,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_we_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_stb_o,
    output logic                 wb_cyc_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i
);
    state_t               state;
    logic [31:0]          src;
    logic [31:0]          dst;
    logic [31:0]          data;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 abort_pend;
    logic                 abort_now;
    logic                 tmo_clr;
    logic                 tmo_en;
    logic                 tmo_expired;

    assign abort_now = abort_pend | abort_i;
    assign tmo_clr   = ~wb_cyc_o;
    assign tmo_en    = wb_stb_o & ~wb_ack_i & ~wb_err_i;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            src          <= '0;
            dst          <= '0;
            data         <= '0;
            remaining    <= '0;
            abort_pend   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            err_code_o   <= ERR_NONE;
            words_done_o <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_sel_o     <= '0;
            wb_stb_o     <= 1'b0;
            wb_cyc_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        src          <= word_adr(src_adr_i);
                        dst          <= word_adr(dst_adr_i);
                        remaining    <= len_i;
                        abort_pend   <= 1'b0;
                        err_o        <= 1'b0;
                        err_code_o   <= ERR_NONE;
                        words_done_o <= '0;
                        busy_o       <= 1'b1;
                        state        <= (len_i == '0) ? S_DONE : S_RD;
                    end
                end
                S_RD, S_WR: begin
                    if (abort_i) abort_pend <= 1'b1;
                    if (!wb_cyc_o) begin
                        // Idle gap between bus cycles: the only point where a pending abort stops us early.
                        if (abort_now) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_ABORT;
                            state      <= S_DONE;
                        end else begin
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_sel_o <= SEL_ALL;
                            wb_we_o  <= (state == S_WR);
                            wb_adr_o <= (state == S_WR) ? dst : src;
                            wb_dat_o <= (state == S_WR) ? data : '0;
                        end
                    end else if (wb_err_i || wb_ack_i || tmo_expired) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        wb_we_o  <= 1'b0;
                        if (wb_err_i) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_BUS;
                            state      <= S_DONE;
                        end else if (!wb_ack_i) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_TIMEOUT;
                            state      <= S_DONE;
                        end else if (state == S_RD) begin
                            data <= wb_dat_i;
                            if (abort_now) begin
                                err_o      <= 1'b1;
                                err_code_o <= ERR_ABORT;
                                state      <= S_DONE;
                            end else begin
                                state <= S_WR;
                            end
                        end else begin
                            src          <= src + 32'd4;
                            dst          <= dst + 32'd4;
                            words_done_o <= words_done_o + 1'b1;
                            remaining    <= remaining - 1'b1;
                            // A finished transfer reports success even if abort arrived on the last word.
                            if (remaining == LEN_WIDTH'(1)) begin
                                state <= S_DONE;
                            end else if (abort_now) begin
                                err_o      <= 1'b1;
                                err_code_o <= ERR_ABORT;
                                state      <= S_DONE;
                            end else begin
                                state <= S_RD;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_block_copy.sv
// Bench for wb_block_copy: negedge-driven Wishbone responder plus a scoreboard of expected bus cycles.
module tb_wb_block_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src_adr;
    logic [31:0] dst_adr;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [8:0]  words_done;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic        wb_err;

    wb_block_copy #(
        .LEN_WIDTH     (9),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .src_adr_i   (src_adr),
        .dst_adr_i   (dst_adr),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .err_code_o  (err_code),
        .words_done_o(words_done),
        .wb_adr_o    (wb_adr),
        .wb_dat_o    (wb_dat),
        .wb_we_o     (wb_we),
        .wb_sel_o    (wb_sel),
        .wb_stb_o    (wb_stb),
        .wb_cyc_o    (wb_cyc),
        .wb_dat_i    (wb_rdat),
        .wb_ack_i    (wb_ack),
        .wb_err_i    (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Responder knobs and observations
    int delay    = 1;
    bit silent   = 1'b0;
    int err_wr   = 0;
    int abort_rd = 0;
    int wr_cnt, rd_seen, ack_cnt, stb_cycles, stb_run, max_stb_run, wait_cnt;
    int viol = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
    endfunction

    task automatic push_words(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{we: 1'b0, adr: s + 32'(4 * i), dat: 32'h0});
            sb.push_back('{we: 1'b1, adr: d + 32'(4 * i), dat: mdl(s + 32'(4 * i))});
        end
    endtask

    task automatic reset_obs();
        wr_cnt = 0; rd_seen = 0; ack_cnt = 0; stb_cycles = 0; max_stb_run = 0;
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, output int lat);
        src_adr = s;
        dst_adr = d;
        len     = 9'(n);
        @(negedge clk);
        start = 1'b1;
        lat   = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                check("busy_after_start", busy, 1);
            end
            if (done) break;
        end
        check("done_seen", done, 1);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    // Responder: acts on the negedge, so ack/err/data are stable at the next posedge.
    initial begin
        logic        prev_stb = 1'b0;
        logic        prev_we  = 1'b0;
        logic [31:0] prev_adr = '0;
        logic [31:0] prev_dat = '0;
        txn_t        t;
        wb_ack = 1'b0; wb_err = 1'b0; wb_rdat = '0; abort = 1'b0; wait_cnt = 0; stb_run = 0;
        forever begin
            @(negedge clk);
            if (!wb_cyc && (wb_sel != 4'h0 || wb_we)) viol++;
            if (wb_cyc != wb_stb) viol++;
            if (wb_stb && wb_sel != 4'hF) viol++;
            if (wb_stb && (wb_ack || wb_err)) viol++;
            if (wb_stb && prev_stb && !wb_ack && !wb_err &&
                (wb_adr != prev_adr || wb_we != prev_we || wb_dat != prev_dat)) viol++;
            prev_stb = wb_stb; prev_we = wb_we; prev_adr = wb_adr; prev_dat = wb_dat;
            abort = 1'b0;
            if (wb_stb) begin
                stb_cycles++;
                stb_run++;
                if (stb_run > max_stb_run) max_stb_run = stb_run;
            end else begin
                stb_run = 0;
            end
            if (wb_ack || wb_err) begin
                wb_ack = 1'b0; wb_err = 1'b0; wait_cnt = 0;
            end else if (wb_stb) begin
                wait_cnt++;
                if (!wb_we && wait_cnt == 1) begin
                    rd_seen++;
                    if (rd_seen == abort_rd) abort = 1'b1;
                end
                if (!silent && wait_cnt >= delay) begin
                    ack_cnt++;
                    if (sb.size() == 0) begin
                        check("sb_unexpected_cycle", wb_adr, 32'hFFFF_FFFF);
                    end else begin
                        t = sb.pop_front();
                        check("bus_we", wb_we, t.we);
                        check("bus_adr", wb_adr, t.adr);
                        if (t.we) check("bus_wdat", wb_dat, t.dat);
                    end
                    if (wb_we) begin
                        wr_cnt++;
                        if (wr_cnt == err_wr) wb_err = 1'b1;
                        else wb_ack = 1'b1;
                    end else begin
                        wb_rdat = mdl(wb_adr);
                        wb_ack  = 1'b1;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        logic done_hit;
        rst = 1'b1; start = 1'b0; src_adr = '0; dst_adr = '0; len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_words", words_done, 0);
        check("rst_cyc", wb_cyc, 0);
        rst = 1'b0;
        @(negedge clk);

        // Four-word copy, zero-wait responder
        reset_obs();
        push_words(32'hF000_0800, 32'h8000_0000, 4);
        run_copy(32'hF000_0800, 32'h8000_0000, 4, lat);
        check("copy4_cycles", ack_cnt, 8);
        check("copy4_err", err, 0);
        check("copy4_code", err_code, 0);
        check("copy4_words", words_done, 4);
        check("copy4_sb_empty", sb.size(), 0);

        // Zero-length request
        reset_obs();
        run_copy(32'h0000_1000, 32'h0000_2000, 0, lat);
        check("len0_latency", lat, 2);
        check("len0_no_cyc", stb_cycles, 0);
        check("len0_err", err, 0);

        // Bus error on the third write
        reset_obs();
        err_wr = 3;
        push_words(32'h0000_0400, 32'h0000_0800, 3);
        run_copy(32'h0000_0400, 32'h0000_0800, 5, lat);
        repeat (3) @(negedge clk);
        check("buserr_err", err, 1);
        check("buserr_code", err_code, 1);
        check("buserr_words", words_done, 2);
        check("buserr_cyc_low", wb_cyc, 0);
        check("buserr_sb_empty", sb.size(), 0);
        err_wr = 0;

        // Silent responder
        reset_obs();
        silent = 1'b1;
        run_copy(32'h0000_0000, 32'h0000_0100, 2, lat);
        check("tmo_stb_len", max_stb_run, 16);
        check("tmo_err", err, 1);
        check("tmo_code", err_code, 2);
        check("tmo_words", words_done, 0);
        silent = 1'b0;

        // Abort during the second read, acks three cycles after strobe
        reset_obs();
        delay    = 3;
        abort_rd = 2;
        push_words(32'h0000_3000, 32'h0000_4000, 1);
        sb.push_back('{we: 1'b0, adr: 32'h0000_3004, dat: 32'h0});
        run_copy(32'h0000_3000, 32'h0000_4000, 4, lat);
        check("abort_code", err_code, 3);
        check("abort_err", err, 1);
        check("abort_words", words_done, 1);
        check("abort_cycles", ack_cnt, 3);
        check("abort_sb_empty", sb.size(), 0);
        abort_rd = 0;
        delay    = 1;

        // Source address wrap; also shows the error flag clears on a new start
        reset_obs();
        push_words(32'hFFFF_FFFC, 32'h0000_0100, 2);
        run_copy(32'hFFFF_FFFF, 32'h0000_0102, 2, lat);
        check("wrap_err", err, 0);
        check("wrap_code", err_code, 0);
        check("wrap_words", words_done, 2);
        check("wrap_sb_empty", sb.size(), 0);

        // Reset while a write is on the bus
        reset_obs();
        delay = 3;
        sb.push_back('{we: 1'b0, adr: 32'h0000_5000, dat: 32'h0});
        src_adr = 32'h0000_5000; dst_adr = 32'h0000_6000; len = 9'd4;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(wb_stb && wb_we) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rstwr_reached_write", wb_stb & wb_we, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstwr_cyc", wb_cyc, 0);
        check("rstwr_stb", wb_stb, 0);
        check("rstwr_busy", busy, 0);
        check("rstwr_words", words_done, 0);
        check("rstwr_adr", wb_adr, 0);
        rst = 1'b0;
        done_hit = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_hit = 1'b1;
        end
        check("rstwr_no_done", done_hit, 0);
        check("rstwr_sb_empty", sb.size(), 0);

        check("protocol_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_block_copy.md
WB_BLOCK_COPY -- requirements
Module: wb_block_copy

Interface
REQ-001 SHALL provide parameter LEN_WIDTH, default 9, word-count width (up to 511 words per transfer).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 255, max cycles waited for ack/err per bus cycle.
REQ-003 clk_i  in  1  sole clock; Wishbone clock domain (clk_50mhz at top level).
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 start_i  in  1  single-cycle request to begin a copy; sampled only in IDLE.
REQ-006 abort_i  in  1  stop the transfer at the next bus-cycle boundary.
REQ-007 src_adr_i  in  32  source byte address; bits [1:0] ignored.
REQ-008 dst_adr_i  in  32  destination byte address; bits [1:0] ignored.
REQ-009 len_i  in  LEN_WIDTH  number of 32-bit words to copy.
REQ-010 busy_o  out  1  high from the start acceptance until DONE is entered.
REQ-011 done_o  out  1  one-cycle pulse at completion, success or failure.
REQ-012 err_o  out  1  sticky failure flag; cleared on the next accepted start.
REQ-013 err_code_o  out  2  failure cause: 0 none, 1 bus err, 2 timeout, 3 abort.
REQ-014 words_done_o  out  LEN_WIDTH  count of words written successfully.
REQ-015 wb_adr_o/wb_dat_o  out  32/32  Wishbone classic initiator address and write data.
REQ-016 wb_we_o/wb_sel_o/wb_stb_o/wb_cyc_o  out  1/4/1/1  Wishbone classic initiator controls.
REQ-017 wb_dat_i/wb_ack_i/wb_err_i  in  32/1/1  Wishbone read data, acknowledge, and error from the responder.

Function
REQ-018 FSM states SHALL be IDLE, RD, WR, DONE.
REQ-019 IDLE + start_i: latch src, dst, and len; clear err_o, err_code_o, and words_done_o; busy_o=1; go to RD, or to DONE if len_i==0 (no bus cycle is issued).
REQ-020 RD: cyc=stb=1, we=0, sel=4'b1111, adr={src[31:2],2'b00}; on ack latch wb_dat_i into the data register, drop cyc/stb in the same edge, go to WR.
REQ-021 WR: cyc=stb=1, we=1, sel=4'b1111, adr={dst[31:2],2'b00}, dat=latched word; on ack src+=4, dst+=4, words_done+=1, remaining-=1; if remaining becomes 0 go to DONE, else go to RD.
REQ-022 cyc/stb SHALL deassert for at least one cycle between consecutive bus cycles, because the responder acks on ~ack.
REQ-023 Outputs SHALL remain stable while stb is high and ack/err is low.
REQ-024 wb_err_i in RD or WR: err_o=1, code=1, go to DONE; the word is not counted.
REQ-025 Per-cycle counter reset on stb rise; counter reaching TIMEOUT_CYCLES without ack/err: drop cyc/stb, err_o=1, code=2, go to DONE.
REQ-026 abort_i during RD/WR SHALL take effect after the current cycle's ack/err/timeout: code=3 unless err/timeout occurred first; abort in IDLE or DONE is ignored.
REQ-027 If ack and err arrive in the same cycle, err SHALL win.
REQ-028 Address increment SHALL wrap modulo 2^32 with no error.
REQ-029 DONE: done_o=1 for one cycle, busy_o=0, then return to IDLE; a start_i asserted during DONE is ignored.
REQ-030 wb_sel_o SHALL be 0 and wb_we_o SHALL be 0 whenever cyc is 0.

Reset
REQ-031 rst_i SHALL force IDLE; all outputs 0, counters 0, err_code 0.
REQ-032 rst_i mid-transfer SHALL drop cyc/stb the following cycle with no done_o pulse.

Structure
REQ-033 FSM encodings, err_code values, and the SEL_ALL constant SHALL live in the shared package twpm_wb_pkg.
REQ-034 The timeout counter SHALL be the sub-module wb_timeout_ctr (inputs clr/en, output expired).

Verification
REQ-035 Copy 4 words 0xF0000800 -> 0x80000000 with a responder acking after 1 cycle -> 8 bus cycles at the correct addresses, data matches, done pulse, err_o=0, words_done=4.
REQ-036 len=0 -> no cyc assertion, done_o pulse 2 cycles after start, busy deasserted.
REQ-037 Responder asserts err on the 3rd write -> err_o=1, code=1, words_done=2, cyc low thereafter.
REQ-038 Responder silent, TIMEOUT_CYCLES=16 -> cyc drops after 16 cycles, code=2, done pulse.
REQ-039 abort_i asserted in the 2nd RD with an ack 3 cycles later -> read completes, no WR issued, code=3, words_done=1.
REQ-040 src=0xFFFFFFFC, len=2 -> second read at 0x00000000; rst_i mid-WR -> cyc=0 next cycle, outputs zero, no done_o.
